// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory copy / fill DMA.
//   dma_state_e : controller states (IDLE, PRIME, STREAM, DONE)
//   WORD_BYTES  : byte stride between consecutive 32-bit words
//   WEN_ALL     : full-word byte-lane write enable
package mem_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } dma_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WEN_ALL    = 4'hF;

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable 32-bit word address register with +4 increment.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_addr_i (takes priority over inc_i)
//   inc_i       : advance by one word; wraps modulo 2^32
//   load_addr_i : value loaded on load_i
//   addr_o      : current address
module dma_addr_gen
  import mem_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        inc_i,
  input  logic [31:0] load_addr_i,
  output logic [31:0] addr_o
);

  logic [31:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_addr_i;
    end else if (inc_i) begin
      addr_d = addr_q + 32'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mem_copy_dma.sv
// Block copy / constant fill engine with XOR checksum of written words.
//   clk, resetn        : clock, asynchronous active-low reset
//   start              : job request, sampled only in IDLE
//   src_addr, dst_addr : word-aligned byte addresses
//   len_words          : number of words (0 = no writes)
//   fill_en/fill_value : write a constant instead of source data
//   busy, done, err    : job status; err/checksum held until next start
//   checksum           : XOR of all words written in the current/last job
//   rd_addr/rd_data    : synchronous read port (data one cycle after address)
//   wr_wen/addr/data   : byte-lane write port (wen only 4'h0 or 4'hF)
module mem_copy_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             fill_en,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      checksum,
  output logic [31:0]      rd_addr,
  input  logic [31:0]      rd_data,
  output logic [3:0]       wr_wen,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data
);

  dma_state_e       state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             fill_en_q;
  logic [31:0]      fill_value_q;
  logic             busy_q, done_q, wen_q, err_q;
  logic [31:0]      checksum_q;
  logic [31:0]      wr_addr_hold_q, wr_data_hold_q;
  logic [31:0]      src_cur, dst_cur;
  logic [31:0]      beat_data;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && start;

  // Source runs one word ahead of destination: it advances in PRIME and on
  // every STREAM beat, so the read for beat k+1 is issued during beat k.
  dma_addr_gen u_src_gen (
    .clk         (clk),
    .rst_n       (resetn),
    .load_i      (accept),
    .inc_i       ((state_q == ST_PRIME) || (state_q == ST_STREAM)),
    .load_addr_i (src_addr),
    .addr_o      (src_cur)
  );

  dma_addr_gen u_dst_gen (
    .clk         (clk),
    .rst_n       (resetn),
    .load_i      (accept),
    .inc_i       (state_q == ST_STREAM),
    .load_addr_i (dst_addr),
    .addr_o      (dst_cur)
  );

  // rd_data arrives in the same cycle it must be written, so the write data
  // path is combinational during STREAM and a held copy is shown otherwise.
  assign beat_data = fill_en_q ? fill_value_q : rd_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      fill_en_q      <= 1'b0;
      fill_value_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wen_q          <= 1'b0;
      err_q          <= 1'b0;
      checksum_q     <= '0;
      wr_addr_hold_q <= '0;
      wr_data_hold_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cnt_q        <= len_words;
            fill_en_q    <= fill_en;
            fill_value_q <= fill_value;
            checksum_q   <= '0;
            err_q        <= 1'b0;
            if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (len_words == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ST_PRIME;
            end
          end
        end
        ST_PRIME: begin
          wen_q   <= 1'b1;
          state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          checksum_q     <= checksum_q ^ beat_data;
          wr_addr_hold_q <= dst_cur;
          wr_data_hold_q <= beat_data;
          if (cnt_q == LEN_W'(1)) begin
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign checksum = checksum_q;
  assign wr_wen   = wen_q ? WEN_ALL : 4'h0;
  assign wr_addr  = (state_q == ST_STREAM) ? dst_cur   : wr_addr_hold_q;
  assign wr_data  = (state_q == ST_STREAM) ? beat_data : wr_data_hold_q;
  assign rd_addr  = ((state_q == ST_PRIME) || (state_q == ST_STREAM)) ? src_cur : '0;

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len_words = '0;
  logic             fill_en = 1'b0;
  logic [31:0]      fill_value = '0;
  logic             busy, done, err;
  logic [31:0]      checksum, rd_addr, wr_addr, wr_data;
  logic [31:0]      rd_data = '0;
  logic [3:0]       wr_wen;

  mem_copy_dma #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len_words  (len_words),
    .fill_en    (fill_en),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_wen     (wr_wen),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read source memory, 16 words aliased over the address space.
  logic [31:0] src_mem [16];
  always @(posedge clk) rd_data <= src_mem[rd_addr[5:2]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observation logs filled once per cycle at the falling edge.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [3:0]  ww[$];
  int          wc[$];
  int          dc[$];
  logic        d_err;
  logic [31:0] d_sum;
  logic        p_busy, p_done;
  logic [31:0] p_rd;
  logic [3:0]  p_wen;

  task automatic tick();
    @(negedge clk);
    if (wr_wen != 4'h0) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      ww.push_back(wr_wen);
      wc.push_back(cyc);
    end
    if (done) begin
      dc.push_back(cyc);
      d_err = err;
      d_sum = checksum;
    end
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic f, input logic [31:0] fv,
                         input int repulse_at, input int rst_at, output int t);
    wa.delete(); wd.delete(); ww.delete(); wc.delete(); dc.delete();
    d_err = 1'bx; d_sum = 'x;
    src_addr = s; dst_addr = d; len_words = LEN_W'(n); fill_en = f; fill_value = fv;
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
    p_busy = busy; p_done = done; p_rd = rd_addr; p_wen = wr_wen;
    // Scramble inputs mid-job: latched values must be used.
    src_addr = 32'h0000_0030; dst_addr = 32'h0000_0800; fill_value = 32'h5555_5555;
    for (int i = 0; i < n + 6; i++) begin
      if (cyc == t + repulse_at) start = 1'b1;
      if (rst_at > 0 && cyc == t + rst_at) begin
        resetn = 1'b0;
        #1;
        check("rst_wen", 32'(wr_wen), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rd_addr", rd_addr, 32'h0);
        check("rst_wr_addr", wr_addr, 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_checksum", checksum, 32'h0);
      end
      tick();
      start = 1'b0;
    end
    if (!resetn) begin
      resetn = 1'b1;
      tick();
    end
  endtask

  task automatic check_writes(input logic [31:0] s, input logic [31:0] d, input int n,
                              input logic f, input logic [31:0] fv, input int t);
    logic [31:0] exp_d;
    check("n_writes", 32'(wa.size()), 32'(n));
    for (int k = 0; k < n && k < wa.size(); k++) begin
      exp_d = f ? fv : src_mem[((s >> 2) + 32'(k)) & 32'hF];
      check($sformatf("wr_addr[%0d]", k), wa[k], d + 32'(4 * k));
      check($sformatf("wr_data[%0d]", k), wd[k], exp_d);
      check($sformatf("wr_wen[%0d]", k), 32'(ww[k]), 32'hF);
      check($sformatf("wr_cyc[%0d]", k), 32'(wc[k] - t), 32'(2 + k));
    end
  endtask

  task automatic check_done(input int t, input int lat, input logic e, input logic [31:0] sum);
    check("n_done", 32'(dc.size()), 32'h1);
    if (dc.size() > 0) begin
      check("done_lat", 32'(dc[0] - t), 32'(lat));
      check("done_err", 32'(d_err), 32'(e));
      check("done_checksum", d_sum, sum);
    end
  endtask

  int t;

  initial begin
    for (int i = 0; i < 16; i++) src_mem[i] = 32'h0101_0101 * 32'(i);
    src_mem[0]  = 32'h1111_1111; src_mem[1] = 32'h2222_2222;
    src_mem[2]  = 32'h4444_4444; src_mem[3] = 32'h8888_8888;
    src_mem[4]  = 32'hA5A5_A5A5; src_mem[5] = 32'h0F0F_0F0F;
    src_mem[6]  = 32'h1234_5678; src_mem[7] = 32'h9ABC_DEF0;
    src_mem[8]  = 32'h0000_0001; src_mem[9] = 32'h0000_0002;
    src_mem[10] = 32'h0000_0004;

    tick(); tick();
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_checksum", checksum, 32'h0);
    check("reset_rd_addr", rd_addr, 32'h0);
    check("reset_wen", 32'(wr_wen), 32'h0);
    check("reset_wr_addr", wr_addr, 32'h0);
    check("reset_wr_data", wr_data, 32'h0);
    resetn = 1'b1;
    tick();

    // Copy 4 words 0x0 -> 0x100
    run_job(32'h0, 32'h100, 4, 1'b0, 32'h0, -100, 0, t);
    check("copy_prime_busy", 32'(p_busy), 32'h1);
    check("copy_prime_rd", p_rd, 32'h0);
    check("copy_prime_wen", 32'(p_wen), 32'h0);
    check_writes(32'h0, 32'h100, 4, 1'b0, 32'h0, t);
    check_done(t, 6, 1'b0, 32'hFFFF_FFFF);
    check("idle_rd_addr", rd_addr, 32'h0);
    check("idle_wr_addr_hold", wr_addr, 32'h10C);
    check("idle_wr_data_hold", wr_data, 32'h8888_8888);
    check("idle_checksum_hold", checksum, 32'hFFFF_FFFF);

    // Fill 3 words at 0x200
    run_job(32'h0, 32'h200, 3, 1'b1, 32'hDEAD_BEEF, -100, 0, t);
    check_writes(32'h0, 32'h200, 3, 1'b1, 32'hDEAD_BEEF, t);
    check_done(t, 5, 1'b0, 32'hDEAD_BEEF);

    // Zero length
    run_job(32'h0, 32'h100, 0, 1'b0, 32'h0, -100, 0, t);
    check("len0_prime_done", 32'(p_done), 32'h1);
    check_writes(32'h0, 32'h100, 0, 1'b0, 32'h0, t);
    check_done(t, 1, 1'b0, 32'h0);

    // Misaligned destination
    run_job(32'h0, 32'h102, 2, 1'b0, 32'h0, -100, 0, t);
    check("mis_prime_busy", 32'(p_busy), 32'h0);
    check_writes(32'h0, 32'h102, 0, 1'b0, 32'h0, t);
    check_done(t, 1, 1'b1, 32'h0);
    check("mis_err_held", 32'(err), 32'h1);

    // start re-pulsed at T+3 of a 4-word job
    run_job(32'h0, 32'h100, 4, 1'b0, 32'h0, 3, 0, t);
    check_writes(32'h0, 32'h100, 4, 1'b0, 32'h0, t);
    check_done(t, 6, 1'b0, 32'hFFFF_FFFF);

    // Destination wraps past 0xFFFF_FFFC
    run_job(32'h20, 32'hFFFF_FFF8, 3, 1'b0, 32'h0, -100, 0, t);
    check_writes(32'h20, 32'hFFFF_FFF8, 3, 1'b0, 32'h0, t);
    check("wrap_last_addr", (wa.size() > 2) ? wa[2] : 32'hDEAD_0000, 32'h0);
    check_done(t, 5, 1'b0, 32'h0000_0007);

    // Reset at T+3 of an 8-word copy
    run_job(32'h0, 32'h300, 8, 1'b0, 32'h0, -100, 3, t);
    check_writes(32'h0, 32'h300, 2, 1'b0, 32'h0, t);
    check("rst_n_done", 32'(dc.size()), 32'h0);

    // Normal job after reset release
    run_job(32'h10, 32'h400, 2, 1'b0, 32'h0, -100, 0, t);
    check_writes(32'h10, 32'h400, 2, 1'b0, 32'h0, t);
    check_done(t, 4, 1'b0, 32'hAAAA_AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Bus initiator that drives the 32-bit synchronous-read memory port and the byte-lane write port used by the SoC's RAM.
- Copies a block of words from a source region to a destination region, or fills a destination region with a constant.
- Computes an XOR checksum of the words written.
- Sits beside the CPU as a boot-time loader and memset/memcpy helper; its write side drives the RAM's wen/addr/wdata port directly.

Parameters:
- LEN_W, 16, width of the word-count input; maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  in  1  system clock, all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  32  source byte address; must be 4-byte aligned.
- dst_addr  in  32  destination byte address; must be 4-byte aligned.
- len_words  in  LEN_W  number of 32-bit words to transfer.
- fill_en  in  1  1 = write fill_value instead of source data.
- fill_value  in  32  constant used when fill_en=1.
- busy  out  1  high from the cycle after start acceptance until the last write cycle inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid while done=1, held until next start.
- checksum  out  32  XOR of all words written in the current/last job; held until next start.
- rd_addr  out  32  read address; the memory returns data one cycle later.
- rd_data  in  32  registered read data for rd_addr of the previous cycle.
- wr_wen  out  4  byte-lane write enables; only 4'h0 or 4'hF are ever driven.
- wr_addr  out  32  write byte address.
- wr_data  out  32  write data.

Behaviour:
- Reset (async, resetn=0): all outputs 0, FSM in IDLE, internal counters 0. Reset asserted mid-job aborts the job immediately: no further writes and no done pulse. This applies even while wr_wen=4'hF.
- FSM states: IDLE, PRIME, STREAM, DONE.
- IDLE, start=1 at cycle T:
  - Latch src, dst, len, fill_en, fill_value.
  - Clear checksum and err.
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0: go to DONE with err=1; no memory traffic.
  - Else if len_words=0: go to DONE with err=0; no writes.
  - Else: go to PRIME.
- PRIME (cycle T+1): rd_addr=src, busy=1, wr_wen=0. Go to STREAM.
- STREAM (cycles T+2 .. T+1+N, index k = 0..N-1):
  - wr_wen=4'hF, wr_addr=dst+4k.
  - wr_data = fill_en ? fill_value : rd_data.
  - checksum ^= wr_data, registered and visible the following cycle.
  - rd_addr = src+4(k+1), including one harmless over-read on the final beat.
  - After k=N-1 go to DONE.
- Throughput is one word per cycle. Total latency from start to done is N+2 cycles (N>0), or 1 cycle for len 0 or err.
- DONE: done=1 and busy=0 for one cycle, wr_wen=0; return to IDLE. start is ignored in DONE.
- start while busy is ignored; latched parameters are unaffected by input changes mid-job.
- Address arithmetic is modulo 2^32; wrap past 0xFFFF_FFFC continues at 0x0000_0000 silently.
- Overlapping regions are not checked. Forward copy order is guaranteed (ascending addresses), so dst<=src overlap is safe.
- Outside STREAM, wr_wen=0. wr_addr and wr_data hold their last values; receivers must ignore them.
- In IDLE, rd_addr=0.
- fill_en=1 still issues reads, keeping one timing path; rd_data is ignored.

Decomposition:
- Package mem_dma_pkg:
  - FSM state encoding (2-bit: IDLE=0, PRIME=1, STREAM=2, DONE=3).
  - WORD_BYTES=4.
  - WEN_ALL=4'hF.
- One natural sub-module, dma_addr_gen: a loadable 32-bit address register with +4 increment, instantiated twice (source and destination). The word counter stays in the top module.

Test Plan:
- Copy: src=0x0000_0000, dst=0x0000_0100, len=4, source words 0x11111111, 0x22222222, 0x44444444, 0x88888888, start at T.
  - Writes occur at T+2..T+5 to 0x100..0x10C with wen=F.
  - done=1 at T+6.
  - checksum=0xFFFFFFFF, err=0.
- Fill: dst=0x200, len=3, fill_en=1, fill_value=0xDEADBEEF.
  - Three writes of 0xDEADBEEF to 0x200, 0x204, 0x208.
  - checksum=0xDEADBEEF.
- Zero length and misalignment:
  - len=0: done at T+1, no wen, err=0.
  - dst=0x102, len=2: done at T+1, err=1, no wen.
- start re-pulsed at T+3 of a 4-word job: ignored; exactly 4 writes and one done pulse.
- Wrap: dst=0xFFFF_FFF8, len=3 → writes to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- resetn low at T+3 of an 8-word copy: outputs 0 immediately, no done. A new job after release completes normally.
